// File: rtl/imem_read_if.sv
// imem_read_if: fetch read request/response bus between fetch stages and the instruction memory.
interface imem_read_if #(
   parameter int ADDRESS_BITS = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 4
);
   logic                          req_valid;
   logic                          req_ready;
   logic [ADDRESS_BITS-1:0]       req_address;
   logic                          flush;
   logic                          resp_valid;
   logic                          resp_ready;
   logic [DATA_WIDTH-1:0]         resp_data;
   logic [ADDRESS_BITS-1:0]       resp_address;
   logic                          resp_error;
   logic [$clog2(FIFO_DEPTH):0]   outstanding;
   modport master (
      output req_valid, req_address, flush, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_address, resp_error, outstanding
   );
   modport slave (
      input  req_valid, req_address, flush, resp_ready,
      output req_ready, resp_valid, resp_data, resp_address, resp_error, outstanding
   );
endinterface

// File: rtl/imem_read_responder.sv
// imem_read_responder: fixed-latency instruction memory read with credit-limited in-order response FIFO; IMEM_WRITE_PORT_EN adds a write port.
module imem_read_responder #(
   parameter int    ADDRESS_BITS = 32,
   parameter int    DATA_WIDTH   = 32,
   parameter int    INDEX_BITS   = 8,
   parameter int    LATENCY      = 2,
   parameter int    FIFO_DEPTH   = 4,
   parameter string INIT_FILE    = ""
) (
   input logic        clock,
   input logic        reset,
   imem_read_if.slave bus
`ifdef IMEM_WRITE_PORT_EN
   ,
   input logic                    write_en,
   input logic [ADDRESS_BITS-1:0] write_address,
   input logic [DATA_WIDTH-1:0]   write_data
`endif
);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int OW    = PW + 1;
   localparam int WORDS = 1 << INDEX_BITS;

   logic [DATA_WIDTH-1:0]   mem [WORDS];
   logic                    accept;
   logic                    req_err;
   logic [INDEX_BITS-1:0]   req_idx;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    push;
   logic [DATA_WIDTH-1:0]   push_data;
   logic [ADDRESS_BITS-1:0] push_address;
   logic                    push_error;
   logic                    do_push;
   logic                    pop;
   logic [PW:0]             wr_ptr;
   logic [PW:0]             rd_ptr;
   logic [OW-1:0]           outstanding;
   logic [DATA_WIDTH-1:0]   f_data [FIFO_DEPTH];
   logic [ADDRESS_BITS-1:0] f_address [FIFO_DEPTH];
   logic                    f_error [FIFO_DEPTH];

   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = DATA_WIDTH'(i);
   end

`ifdef IMEM_WRITE_PORT_EN
   logic wr_ok;
   assign wr_ok = write_en && write_address[1:0] == 2'b00 && (write_address >> (INDEX_BITS + 2)) == '0;
   always @(posedge clock) begin
      if (wr_ok) mem[write_address[INDEX_BITS+1:2]] <= write_data;
   end
`endif

   assign bus.req_ready = outstanding < OW'(FIFO_DEPTH) && !bus.flush;
   assign accept        = bus.req_valid && bus.req_ready;
   assign req_err       = bus.req_address[1:0] != 2'b00 || (bus.req_address >> (INDEX_BITS + 2)) != '0;
   assign req_idx       = bus.req_address[INDEX_BITS+1:2];
   assign rd_data       = req_err ? '0 : mem[req_idx];

   generate
      if (LATENCY == 1) begin : g_direct
         assign push         = accept;
         assign push_data    = rd_data;
         assign push_address = bus.req_address;
         assign push_error   = req_err;
      end else begin : g_pipe
         logic                    v [LATENCY-1];
         logic [DATA_WIDTH-1:0]   d [LATENCY-1];
         logic [ADDRESS_BITS-1:0] a [LATENCY-1];
         logic                    e [LATENCY-1];
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) for (int k = 0; k < LATENCY - 1; k++) v[k] <= 1'b0;
            else begin
               v[0] <= accept && !bus.flush;
               for (int k = 1; k < LATENCY - 1; k++) v[k] <= v[k-1] && !bus.flush;
            end
         end
         always_ff @(posedge clock) begin
            d[0] <= rd_data;
            a[0] <= bus.req_address;
            e[0] <= req_err;
            for (int k = 1; k < LATENCY - 1; k++) begin
               d[k] <= d[k-1];
               a[k] <= a[k-1];
               e[k] <= e[k-1];
            end
         end
         assign push         = v[LATENCY-2];
         assign push_data    = d[LATENCY-2];
         assign push_address = a[LATENCY-2];
         assign push_error   = e[LATENCY-2];
      end
   endgenerate

   assign do_push          = push && !bus.flush;
   assign bus.resp_valid   = wr_ptr != rd_ptr;
   assign pop              = bus.resp_valid && bus.resp_ready && !bus.flush;
   assign bus.resp_data    = bus.resp_valid ? f_data[rd_ptr[PW-1:0]] : '0;
   assign bus.resp_address = bus.resp_valid ? f_address[rd_ptr[PW-1:0]] : '0;
   assign bus.resp_error   = bus.resp_valid && f_error[rd_ptr[PW-1:0]];
   assign bus.outstanding  = outstanding;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
      end else if (bus.flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
      end else begin
         wr_ptr      <= wr_ptr + (PW+1)'(do_push);
         rd_ptr      <= rd_ptr + (PW+1)'(pop);
         outstanding <= outstanding + OW'(accept) - OW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         f_data[wr_ptr[PW-1:0]]    <= push_data;
         f_address[wr_ptr[PW-1:0]] <= push_address;
         f_error[wr_ptr[PW-1:0]]   <= push_error;
      end
   end
endmodule

// File: tb/tb_imem_read_responder.sv
// tb_imem_read_responder: directed self-checking bench for imem_read_responder.
module tb_imem_read_responder;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   imem_read_if #(.ADDRESS_BITS(32), .DATA_WIDTH(32), .FIFO_DEPTH(4)) bus ();

`ifdef IMEM_WRITE_PORT_EN
   logic        write_en = 1'b0;
   logic [31:0] write_address = '0;
   logic [31:0] write_data = '0;
   imem_read_responder #(.ADDRESS_BITS(32), .DATA_WIDTH(32), .INDEX_BITS(8), .LATENCY(2), .FIFO_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .bus(bus.slave),
      .write_en(write_en), .write_address(write_address), .write_data(write_data));
`else
   imem_read_responder #(.ADDRESS_BITS(32), .DATA_WIDTH(32), .INDEX_BITS(8), .LATENCY(2), .FIFO_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .bus(bus.slave));
`endif

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      bus.req_valid = 0; bus.req_address = '0; bus.flush = 0; bus.resp_ready = 0;
      reset = 0;
      repeat (3) @(posedge clock);
      #1 reset = 1;
      tick();
      checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", bus.resp_valid); end
      checks++; if (bus.resp_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.resp_data); end
      checks++; if (bus.resp_address !== 32'h0) begin failures++; $display("FAIL reset_address got=%0h exp=0", bus.resp_address); end
      checks++; if (bus.resp_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%0h exp=0", bus.resp_error); end
      checks++; if (bus.outstanding !== 3'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", bus.outstanding); end
      checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0h exp=1", bus.req_ready); end
   endtask

   task automatic test_single();
      bus.resp_ready = 1;
      bus.req_valid = 1; bus.req_address = 32'h8;
      tick();
      bus.req_valid = 0;
      #1;
      checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0h exp=0", bus.resp_valid); end
      checks++; if (bus.outstanding !== 3'd1) begin failures++; $display("FAIL single_outstanding1 got=%0d exp=1", bus.outstanding); end
      tick();
      checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0h exp=1", bus.resp_valid); end
      checks++; if (bus.resp_data !== 32'h2) begin failures++; $display("FAIL single_data got=%0h exp=2", bus.resp_data); end
      checks++; if (bus.resp_address !== 32'h8) begin failures++; $display("FAIL single_address got=%0h exp=8", bus.resp_address); end
      checks++; if (bus.resp_error !== 1'b0) begin failures++; $display("FAIL single_error got=%0h exp=0", bus.resp_error); end
      tick();
      checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL single_after_valid got=%0h exp=0", bus.resp_valid); end
      checks++; if (bus.outstanding !== 3'd0) begin failures++; $display("FAIL single_outstanding0 got=%0d exp=0", bus.outstanding); end
   endtask

   task automatic test_back_to_back();
      bus.resp_ready = 1;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            bus.req_valid = 1; bus.req_address = 32'(4 * i);
            #1;
            checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_req_ready%0d got=%0h exp=1", i, bus.req_ready); end
         end else bus.req_valid = 0;
         tick();
         if (i >= 1) begin
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'(i - 1))
               begin failures++; $display("FAIL b2b_resp%0d got valid=%0h data=%0h exp valid=1 data=%0h", i - 1, bus.resp_valid, bus.resp_data, i - 1); end
         end
      end
      tick();
      checks++; if (bus.resp_valid !== 1'b0 || bus.outstanding !== 3'd0)
         begin failures++; $display("FAIL b2b_drain got valid=%0h outstanding=%0d exp 0 0", bus.resp_valid, bus.outstanding); end
   endtask

   task automatic test_backpressure();
      int  got;
      logic acc, pop;
      logic [31:0] d;
      bus.resp_ready = 0;
      for (int k = 0; k < 4; k++) begin
         bus.req_valid = 1; bus.req_address = 32'(32'h10 + 4 * k);
         tick();
      end
      bus.req_address = 32'h20;
      #1;
      checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL bp_req_ready got=%0h exp=0", bus.req_ready); end
      checks++; if (bus.outstanding !== 3'd4) begin failures++; $display("FAIL bp_outstanding got=%0d exp=4", bus.outstanding); end
      tick();
      tick();
      checks++; if (bus.req_ready !== 1'b0 || bus.outstanding !== 3'd4)
         begin failures++; $display("FAIL bp_hold got ready=%0h outstanding=%0d exp 0 4", bus.req_ready, bus.outstanding); end
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h4)
         begin failures++; $display("FAIL bp_head got valid=%0h data=%0h exp 1 4", bus.resp_valid, bus.resp_data); end
      bus.resp_ready = 1;
      got = 0;
      for (int c = 0; c < 20 && got < 5; c++) begin
         #1;
         acc = bus.req_valid && bus.req_ready;
         pop = bus.resp_valid;
         d = bus.resp_data;
         tick();
         if (acc) bus.req_valid = 0;
         if (pop) begin
            checks++; if (d !== 32'(4 + got)) begin failures++; $display("FAIL bp_order%0d got=%0h exp=%0h", got, d, 4 + got); end
            got++;
         end
      end
      checks++; if (got != 5) begin failures++; $display("FAIL bp_timeout got=%0d responses exp=5", got); end
      bus.req_valid = 0;
      checks++; if (bus.outstanding !== 3'd0 || bus.resp_valid !== 1'b0)
         begin failures++; $display("FAIL bp_drain got outstanding=%0d valid=%0h exp 0 0", bus.outstanding, bus.resp_valid); end
   endtask

   task automatic test_error();
      logic [31:0] addrs [3] = '{32'h6, 32'h400, 32'h4};
      logic [31:0] datas [3] = '{32'h0, 32'h0, 32'h1};
      logic        errs  [3] = '{1'b1, 1'b1, 1'b0};
      bus.resp_ready = 1;
      for (int v = 0; v < 3; v++) begin
         bus.req_valid = 1; bus.req_address = addrs[v];
         tick();
         bus.req_valid = 0;
         tick();
         checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== datas[v] || bus.resp_error !== errs[v])
            begin failures++; $display("FAIL err_addr_%0h got valid=%0h data=%0h err=%0h exp 1 %0h %0h", addrs[v], bus.resp_valid, bus.resp_data, bus.resp_error, datas[v], errs[v]); end
         tick();
      end
   endtask

   task automatic test_flush();
      int stale;
      bus.resp_ready = 0;
      bus.req_valid = 1; bus.req_address = 32'h0;
      tick();
      bus.req_address = 32'h4;
      tick();
      checks++; if (bus.outstanding !== 3'd2 || bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h0)
         begin failures++; $display("FAIL flush_pre got outstanding=%0d valid=%0h data=%0h exp 2 1 0", bus.outstanding, bus.resp_valid, bus.resp_data); end
      bus.req_address = 32'h8; bus.flush = 1; bus.resp_ready = 1;
      #1;
      checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL flush_req_ready got=%0h exp=0", bus.req_ready); end
      tick();
      bus.flush = 0; bus.req_valid = 0;
      #1;
      checks++; if (bus.resp_valid !== 1'b0 || bus.outstanding !== 3'd0 || bus.resp_data !== 32'h0)
         begin failures++; $display("FAIL flush_after got valid=%0h outstanding=%0d data=%0h exp 0 0 0", bus.resp_valid, bus.outstanding, bus.resp_data); end
      stale = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus.resp_valid !== 1'b0 || bus.outstanding !== 3'd0) stale++;
      end
      checks++; if (stale != 0) begin failures++; $display("FAIL flush_stale got=%0d stale cycles exp=0", stale); end
      bus.req_valid = 1; bus.req_address = 32'h10;
      tick();
      bus.req_valid = 0;
      tick();
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h4 || bus.resp_address !== 32'h10)
         begin failures++; $display("FAIL flush_next got valid=%0h data=%0h addr=%0h exp 1 4 10", bus.resp_valid, bus.resp_data, bus.resp_address); end
      tick();
      checks++; if (bus.outstanding !== 3'd0) begin failures++; $display("FAIL flush_end_outstanding got=%0d exp=0", bus.outstanding); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_error();
      test_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end
endmodule
